// File: rtl/link_scheduler_pkg.sv
// Shared types and constants for the link scheduler and its arbiter.
package link_scheduler_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int DEF_TIMEOUT = 512;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_RX = 2'd2,
    RESP    = 2'd3
  } link_state_t;

endpackage

// File: rtl/link_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: favours the requester not served last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       servedId,
  output logic [1:0] grant
);

  logic favour;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = favour ? 2'b10 : 2'b01;
  end

  // Pointer moves only when a frame's response is retired, not at grant time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       favour <= 1'b0;
    else if (advance) favour <= ~servedId;
  end

endmodule

// File: rtl/link_scheduler.sv
// Single-frame-in-flight scheduler: arbitrates two nibble requesters, launches a
// coded frame, waits for the echo (or times out) and returns a checked response.
module link_scheduler
  import link_scheduler_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [NIBBLE_W-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [NIBBLE_W-1:0] req1_data,
  output logic                req1_ready,
  output logic [NIBBLE_W-1:0] tx_code,
  output logic                tx_start,
  input  logic                rx_valid,
  input  logic [NIBBLE_W-1:0] rx_code,
  output logic                resp_valid,
  output logic                resp_id,
  output logic [NIBBLE_W-1:0] resp_data,
  output logic                resp_err,
  input  logic                resp_ready,
  output logic [CNT_W-1:0]    err_count,
  output link_state_t         dbgState
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  link_state_t      state;
  logic [TMR_W-1:0] timer;
  logic [1:0]       grant;
  logic             accept;
  logic             respAccept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and the source holds its data
  // until the transfer. Requests are accepted only in IDLE, responses only in RESP.
  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  assign accept     = (state == IDLE) && (grant != 2'b00);
  assign respAccept = (state == RESP) && resp_ready;
  assign dbgState   = state;

  rr_arbiter2 uArb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1_valid, req0_valid}),
    .advance  (respAccept),
    .servedId (resp_id),
    .grant    (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      tx_code    <= '0;
      tx_start   <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_code  <= grant[1] ? req1_data : req0_data;
            resp_id  <= grant[1];
            tx_start <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          tx_start <= 1'b0;
          timer    <= '0;
          state    <= WAIT_RX;
        end
        WAIT_RX: begin
          // A late echo landing on the timeout cycle still counts as received.
          if (rx_valid) begin
            resp_data  <= rx_code;
            resp_err   <= (rx_code != tx_code);
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timer == TMR_LAST) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            if (resp_err && (err_count != {CNT_W{1'b1}}))
              err_count <= err_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_scheduler.sv
// Self-checking bench for link_scheduler: per-scenario tasks against a frame-level model.
module tb_link_scheduler;
  import link_scheduler_pkg::*;

  localparam int TO = 32;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]    req0_data, req1_data, tx_code, rx_code, resp_data;
  logic          tx_start, rx_valid, resp_valid, resp_id, resp_err, resp_ready;
  logic [CW-1:0] err_count;
  link_state_t   dbgState;

  int nPass = 0;
  int nTotal = 0;
  logic favour;
  int errModel;

  typedef struct packed {
    logic [1:0]    rdy;
    logic          busyRdy;
    logic          start1;
    logic          start2;
    logic [3:0]    code;
    logic [7:0]    respAt;
    logic          rid;
    logic [3:0]    rdata;
    logic          rerr;
    logic          stable;
    logic          after;
    logic [CW-1:0] errCnt;
  } frame_t;

  // clock / reset
  always #5 clk = ~clk;

  link_scheduler #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_code    (tx_code),
    .tx_start   (tx_start),
    .rx_valid   (rx_valid),
    .rx_code    (rx_code),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .err_count  (err_count),
    .dbgState   (dbgState)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running need finished");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    rx_valid = 0; rx_code = 0; resp_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    favour = 1'b0;
    errModel = 0;
  endtask

  // driver: runs one frame from an IDLE negedge and records what the DUT did
  task automatic run_frame(input logic v0, input logic v1, input logic [3:0] d0,
                           input logic [3:0] d1, input int rxAt, input logic [3:0] rxc,
                           input int hold, output frame_t o);
    int w;
    o = '0;
    o.stable = 1'b1;
    o.respAt = '1;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    #1 o.rdy = {req1_ready, req0_ready};
    @(negedge clk);
    o.start1 = tx_start;
    o.code = tx_code;
    o.busyRdy = req0_ready | req1_ready;
    @(negedge clk);
    o.start2 = tx_start;
    w = 1;
    while (w <= 4 * TO) begin
      o.busyRdy = o.busyRdy | req0_ready | req1_ready;
      if (w == rxAt) begin rx_valid = 1; rx_code = rxc; end
      @(negedge clk);
      rx_valid = 0;
      if (resp_valid) begin o.respAt = 8'(w); break; end
      w++;
    end
    o.rid = resp_id; o.rdata = resp_data; o.rerr = resp_err;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin rx_valid = 1; rx_code = ~resp_data; end
      @(negedge clk);
      rx_valid = 0;
      if (!resp_valid || resp_id !== o.rid || resp_data !== o.rdata ||
          resp_err !== o.rerr || req0_ready || req1_ready) o.stable = 1'b0;
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    o.after = resp_valid;
    o.errCnt = err_count;
    req0_valid = 0; req1_valid = 0;
  endtask

  // reference model: frame outcome from the arbitration/echo/timeout rules
  task automatic predict(input logic v0, input logic v1, input logic [3:0] d0,
                         input logic [3:0] d1, input int rxAt, input logic [3:0] rxc,
                         output frame_t e);
    logic win, hit;
    win = (v0 && v1) ? favour : v1;
    hit = (rxAt >= 1) && (rxAt <= TO);
    e = '0;
    e.rdy = win ? 2'b10 : 2'b01;
    e.start1 = 1'b1;
    e.code = win ? d1 : d0;
    e.respAt = hit ? 8'(rxAt) : 8'(TO);
    e.rid = win;
    e.rdata = hit ? rxc : 4'h0;
    e.rerr = hit ? (rxc != e.code) : 1'b1;
    e.stable = 1'b1;
    if (e.rerr && errModel < CNT_MAX) errModel++;
    e.errCnt = CW'(errModel);
    favour = ~win;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    nTotal++;
    if ({tx_code, tx_start, resp_valid, resp_id, resp_data, resp_err, err_count, dbgState} !== '0)
      $display("FAIL reset_outputs got %h need 0",
               {tx_code, tx_start, resp_valid, resp_id, resp_data, resp_err, err_count, dbgState});
    else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_valid = 1; rx_code = 4'h5;
    @(negedge clk);
    rx_valid = 0;
    @(negedge clk);
    nTotal++;
    if (resp_valid !== 1'b0 || dbgState !== IDLE)
      $display("FAIL idle_rx_ignored got valid=%b state=%0d need valid=0 state=0", resp_valid, dbgState);
    else nPass++;
  endtask

  task automatic test_basic();
    frame_t o, e;
    run_frame(1, 0, 4'hA, 4'h0, 20, 4'hA, 0, o);
    predict(1, 0, 4'hA, 4'h0, 20, 4'hA, e);
    nTotal++;
    if (o !== e) $display("FAIL basic_frame got %h need %h", o, e); else nPass++;
  endtask

  task automatic test_back_to_back();
    frame_t o, e;
    logic [3:0] rxc;
    int rxAt;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      rxAt = $urandom_range(1, TO);
      rxc = favour ? 4'h5 : 4'h3;
      run_frame(1, 1, 4'h3, 4'h5, rxAt, rxc, 0, o);
      predict(1, 1, 4'h3, 4'h5, rxAt, rxc, e);
      nTotal++;
      if (o !== e) $display("FAIL b2b_frame%0d got %h need %h", i, o, e); else nPass++;
      nTotal++;
      if (o.rid !== i[0]) $display("FAIL b2b_alternate%0d got id=%b need %b", i, o.rid, i[0]);
      else nPass++;
    end
  endtask

  task automatic test_mismatch();
    frame_t o, e;
    run_frame(0, 1, 4'h0, 4'h6, 5, 4'h7, 0, o);
    predict(0, 1, 4'h0, 4'h6, 5, 4'h7, e);
    nTotal++;
    if (o !== e) $display("FAIL mismatch_frame got %h need %h", o, e); else nPass++;
    nTotal++;
    if (o.errCnt !== CW'(1)) $display("FAIL mismatch_errcount got %0d need 1", o.errCnt); else nPass++;
  endtask

  task automatic test_timeout();
    frame_t o, e;
    run_frame(1, 0, 4'h9, 4'h0, 0, 4'h0, 0, o);
    predict(1, 0, 4'h9, 4'h0, 0, 4'h0, e);
    nTotal++;
    if (o !== e) $display("FAIL timeout_frame got %h need %h", o, e); else nPass++;
    run_frame(0, 1, 4'h0, 4'hC, TO, 4'hC, 0, o);
    predict(0, 1, 4'h0, 4'hC, TO, 4'hC, e);
    nTotal++;
    if (o !== e) $display("FAIL timeout_edge_rx got %h need %h", o, e); else nPass++;
  endtask

  task automatic test_hold();
    frame_t o, e;
    run_frame(1, 1, 4'h1, 4'hE, 7, 4'h2, 10, o);
    predict(1, 1, 4'h1, 4'hE, 7, 4'h2, e);
    nTotal++;
    if (o !== e) $display("FAIL hold_frame got %h need %h", o, e); else nPass++;
  endtask

  task automatic test_random();
    frame_t o, e;
    logic [1:0] vv;
    logic [3:0] d0, d1, rxc;
    int rxAt, hold;
    for (int i = 0; i < 24; i++) begin
      vv = 2'($urandom_range(1, 3));
      d0 = 4'($urandom_range(0, 3));
      d1 = 4'($urandom_range(0, 3));
      rxc = 4'($urandom_range(0, 3));
      rxAt = $urandom_range(0, TO + 3);
      hold = $urandom_range(0, 3);
      run_frame(vv[0], vv[1], d0, d1, rxAt, rxc, hold, o);
      predict(vv[0], vv[1], d0, d1, rxAt, rxc, e);
      nTotal++;
      if (o !== e) $display("FAIL random_frame%0d got %h need %h", i, o, e); else nPass++;
    end
  endtask

  task automatic test_saturation();
    frame_t o, e;
    int satTab[5] = '{1, 2, 3, 3, 3};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_frame(1, 0, 4'h4, 4'h0, 3, 4'hB, 0, o);
      predict(1, 0, 4'h4, 4'h0, 3, 4'hB, e);
      nTotal++;
      if (o.errCnt !== CW'(satTab[i]))
        $display("FAIL saturation%0d got %0d need %0d", i, o.errCnt, satTab[i]);
      else nPass++;
    end
  endtask

  task automatic test_reset_mid();
    frame_t o, e;
    logic seen;
    req0_valid = 1; req0_data = 4'h9;
    @(negedge clk);
    req0_valid = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nTotal++;
    if ({tx_code, tx_start, resp_valid, resp_id, resp_data, resp_err, err_count, dbgState} !== '0)
      $display("FAIL midreset_outputs got %h need 0",
               {tx_code, tx_start, resp_valid, resp_id, resp_data, resp_err, err_count, dbgState});
    else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    favour = 1'b0;
    errModel = 0;
    rx_valid = 1; rx_code = 4'h9;
    seen = 1'b0;
    @(negedge clk);
    rx_valid = 0;
    repeat (6) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    nTotal++;
    if (seen !== 1'b0 || dbgState !== IDLE)
      $display("FAIL midreset_no_resp got seen=%b state=%0d need seen=0 state=0", seen, dbgState);
    else nPass++;
    run_frame(1, 1, 4'h8, 4'h2, 4, 4'h8, 0, o);
    predict(1, 1, 4'h8, 4'h2, 4, 4'h8, e);
    nTotal++;
    if (o !== e) $display("FAIL midreset_resume got %h need %h", o, e); else nPass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_hold();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
